// File: rtl/project_pwm_peripheral_pkg.sv
// Shared definitions for the PWM peripheral capture path.
// Holds the capture FSM state codes and the default counter width.
// No ports; imported by the capture top and its sub-modules.

package project_pwm_peripheral_pkg;

    // Default width of the high/period counters and result registers.
    localparam int unsigned CNT_W_DEFAULT = 16;

    // Capture FSM state codes.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARM  = 2'd1;
    localparam logic [1:0] HIGH = 2'd2;
    localparam logic [1:0] LOW  = 2'd3;

    typedef enum logic [1:0] {
        StIdle = IDLE,
        StArm  = ARM,
        StHigh = HIGH,
        StLow  = LOW
    } cap_state_e;

endpackage

// File: rtl/project_pwm_peripheral_sync_filter.sv
// Pin conditioning for the PWM capture block.
// Synchronises the asynchronous PWM pin, optionally glitch-filters it and
// produces single-cycle rise/fall strobes of the conditioned level.
// Build option: PWM_CAPTURE_FILTER_EN adds a FILT_LEN-cycle glitch filter
// (and the FILT_LEN parameter); without it the synchroniser output is used as is.
// Ports:
//   i_clk      system clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   i_pwm      asynchronous PWM pin
//   o_rise     one-cycle strobe, conditioned level went 0 -> 1
//   o_fall     one-cycle strobe, conditioned level went 1 -> 0

module project_pwm_peripheral_sync_filter #(
    parameter int unsigned SYNC_STAGES = 2
`ifdef PWM_CAPTURE_FILTER_EN
    ,
    parameter int unsigned FILT_LEN    = 3
`endif
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_pwm,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   raw;
    logic                   level;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_pwm};
        raw    = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int unsigned FCNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic              filt_q, filt_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    // The filtered level follows the raw sample only once it has disagreed for
    // FILT_LEN consecutive cycles; both edges see the same delay, so widths hold.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (raw != filt_q) begin
            if (fcnt_q == FCNT_W'(FILT_LEN - 1)) begin
                filt_d = raw;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign level = filt_q;
`else
    assign level = raw;
`endif

    always_comb begin
        prev_d = level;
        o_rise = level & ~prev_q;
        o_fall = ~level & prev_q;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/project_pwm_peripheral_capture.sv
// PWM input capture: measures high time and rise-to-rise period of an
// external PWM waveform in i_clk ticks, one result per complete cycle.
// The first (partial) cycle after arming is never reported; a period that
// reaches the counter limit sets a sticky overflow flag and re-arms.
// Build option: PWM_CAPTURE_FILTER_EN enables the pin glitch filter and the
// FILT_LEN parameter.
// Ports:
//   i_clk           system clock, rising edge
//   i_reset_n       asynchronous active-low reset
//   i_en            capture enable; low forces IDLE and discards the measurement
//   i_pwm           asynchronous PWM pin
//   i_ovf_clr       one-cycle pulse clearing o_overflow
//   o_high_ticks    last measured high time
//   o_period_ticks  last measured period
//   o_valid         one-cycle pulse, new result on o_*_ticks
//   o_overflow      sticky overflow flag

module project_pwm_peripheral_capture
    import project_pwm_peripheral_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
`ifdef PWM_CAPTURE_FILTER_EN
    ,
    parameter int unsigned FILT_LEN    = 3
`endif
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_en,
    input  logic             i_pwm,
    input  logic             i_ovf_clr,
    output logic [CNT_W-1:0] o_high_ticks,
    output logic [CNT_W-1:0] o_period_ticks,
    output logic             o_valid,
    output logic             o_overflow
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic             rise, fall;
    cap_state_e       state_q, state_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_res_q, high_res_d;
    logic [CNT_W-1:0] period_res_q, period_res_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    project_pwm_peripheral_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES)
`ifdef PWM_CAPTURE_FILTER_EN
        ,
        .FILT_LEN    (FILT_LEN)
`endif
    ) u_sync_filter (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_pwm     (i_pwm),
        .o_rise    (rise),
        .o_fall    (fall)
    );

    always_comb begin
        state_d      = state_q;
        high_d       = high_q;
        period_d     = period_q;
        high_res_d   = high_res_q;
        period_res_d = period_res_q;
        valid_d      = 1'b0;
        // A new overflow below overrides this, so set wins over clear.
        ovf_d        = ovf_q & ~i_ovf_clr;

        if (!i_en) begin
            state_d  = StIdle;
            high_d   = '0;
            period_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StArm;
                end
                StArm: begin
                    if (rise) begin
                        high_d   = CntOne;
                        period_d = CntOne;
                        state_d  = StHigh;
                    end
                end
                StHigh: begin
                    if (period_q == CntMax) begin
                        ovf_d    = 1'b1;
                        high_d   = '0;
                        period_d = '0;
                        state_d  = StArm;
                    end else begin
                        period_d = period_q + 1'b1;
                        if (fall) begin
                            state_d = StLow;
                        end else begin
                            high_d = high_q + 1'b1;
                        end
                    end
                end
                StLow: begin
                    if (rise) begin
                        // Report and start the next cycle on the same edge.
                        high_res_d   = high_q;
                        period_res_d = period_q;
                        valid_d      = 1'b1;
                        high_d       = CntOne;
                        period_d     = CntOne;
                        state_d      = StHigh;
                    end else if (period_q == CntMax) begin
                        ovf_d    = 1'b1;
                        high_d   = '0;
                        period_d = '0;
                        state_d  = StArm;
                    end else begin
                        period_d = period_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= StIdle;
            high_q       <= '0;
            period_q     <= '0;
            high_res_q   <= '0;
            period_res_q <= '0;
            valid_q      <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            high_q       <= high_d;
            period_q     <= period_d;
            high_res_q   <= high_res_d;
            period_res_q <= period_res_d;
            valid_q      <= valid_d;
            ovf_q        <= ovf_d;
        end
    end

    always_comb begin
        o_high_ticks   = high_res_q;
        o_period_ticks = period_res_q;
        o_valid        = valid_q;
        o_overflow     = ovf_q;
    end

endmodule
